spi_reg_peripheral: RTL and testbench
=====================================

Name: spi_reg_peripheral

Overview:
Write-only SPI (mode 0) target that receives register writes from an external controller and holds the five control registers consumed by pwm_peripheral. These are en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle. The block sits directly upstream of pwm_peripheral inside tt_um_uwasic_onboarding_yohann, fed from ui_in[0] (SCLK), ui_in[1] (COPI) and ui_in[2] (nCS). All SPI pins are asynchronous to clk and are oversampled.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2).
MAX_ADDR, 4, highest valid register address; writes above it are discarded.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock, asynchronous to clk.
copi  input  1  SPI data, controller to peripheral.
ncs  input  1  SPI chip select, active low.
en_reg_out_7_0  output  8  register at address 0x00.
en_reg_out_15_8  output  8  register at address 0x01.
en_reg_pwm_7_0  output  8  register at address 0x02.
en_reg_pwm_15_8  output  8  register at address 0x03.
pwm_duty_cycle  output  8  register at address 0x04.
wr_strobe  output  1  one-clk pulse when a register is committed.

Behaviour:
- One clock, clk; reset is asynchronous and active-low on rst_n. All state, including synchronizers, is reset.
- Reset values:
  - All five registers 0x00.
  - wr_strobe 0.
  - Bit counter 0; shift register 0.
  - Synchronizers preset to the idle bus state: sclk=0, copi=0, ncs=1.
- Input conditioning: each of sclk, copi and ncs passes through a SYNC_STAGES flip-flop chain. One extra flop per signal provides edge detection.
  - sclk_rise = synchronized sclk 0→1.
  - ncs_fall and ncs_rise are derived the same way.
- Timing requirement: SCLK high and low phases are each ≥ 3 clk periods. Faster SCLK is out of spec and behaviour is undefined.
- Frame format: 16 bits, MSB first, sampled on sclk_rise.
  - Bit 15 is R/W: 1 = write, 0 = read.
  - Bits 14:8 are the 7-bit address.
  - Bits 7:0 are the data.
- Bit capture states:
  - ncs_fall: bit counter ← 0, shift register ← 0, start of frame.
  - While synchronized ncs = 0 and sclk_rise: if counter < 16, shift register ← {shift[14:0], copi_sync} and counter ← counter + 1.
  - Once counter = 16, further SCLK edges are ignored; the counter saturates and the shift register holds.
  - sclk_rise while ncs = 1 has no effect.
- Commit on ncs_rise. A commit occurs only if all of the following hold:
  - counter == 16;
  - shift[15] == 1;
  - shift[14:8] ≤ MAX_ADDR.
- When a commit occurs:
  - The addressed register ← shift[7:0] on the clk edge after ncs_rise is detected.
  - wr_strobe = 1 for exactly that one cycle.
- Any other ncs_rise is discarded with no register change and no strobe. This covers short frames, read frames and out-of-range addresses.
- Latency: register update is 1 clk after ncs_rise detection. From the physical nCS rising edge this is SYNC_STAGES + 2 clk.
- At most one register is written per frame. Registers are otherwise stable and glitch-free; they are driven directly from flops.
- Reset asserted mid-frame: the frame is lost. After reset release, the first valid frame must begin with a fresh ncs_fall.
- Frame simultaneous with reset release: if ncs is already low at reset release, no ncs_fall is seen and that frame is not accepted.
- Back-to-back frames separated by ≥ 3 clk of nCS high are each processed independently.

Test Plan:
- Reset check: hold rst_n low, drive random SCLK/COPI/nCS, release → all five registers 0x00 and wr_strobe never asserted.
- Write each address: send frames 0x80F0, 0x81CC, 0x82AA, 0x8355, 0x8480 with SCLK = clk/10 → registers read 0xF0, 0xCC, 0xAA, 0x55, 0x80. wr_strobe pulses exactly 5 times, each pulse SYNC_STAGES + 2 clk after the nCS rise.
- Rejected frames:
  - Read frame 0x0412 → pwm_duty_cycle unchanged.
  - Address 0x05 frame 0x8512 → no register changes.
  - 12-bit truncated frame → no change.
  - No wr_strobe for any of the three.
- Over-length frame: clock 20 bits, first 16 = 0x8233, then 4 extra 1-bits → en_reg_pwm_7_0 = 0x33 (extra bits ignored).
- Reset mid-frame: assert rst_n low after 8 bits of 0x84FF, release, then send 0x8407 → pwm_duty_cycle = 0x07. No write of 0xFF occurs at any point.
- Idle SCLK noise: toggle SCLK 30 times with nCS high, then send 0x8101 → en_reg_out_15_8 = 0x01 and the other registers are unchanged.

Source files
------------

// File: rtl/spi_reg_peripheral_if.sv
// -----------------------------------------------------------------------------
// spi_reg_peripheral_if
//   The three SPI bus pins between an external controller and the register
//   peripheral.
//
//   sclk : SPI clock, driven by the controller, asynchronous to any clk
//   copi : serial data, controller to peripheral
//   ncs  : chip select, active low
//
//   Modports
//     master : the controller side; drives all three pins
//     slave  : the peripheral side; only observes them
// -----------------------------------------------------------------------------
interface spi_reg_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_reg_peripheral.sv
// -----------------------------------------------------------------------------
// spi_reg_peripheral
//   Write-only SPI mode-0 target holding the five control registers used by
//   pwm_peripheral. The SPI pins are oversampled by clk through synchronizer
//   chains. A frame is 16 bits, MSB first: {rw, addr[6:0], data[7:0]}. A write
//   (rw = 1) of exactly 16 or more bits to an address <= MAX_ADDR is committed
//   when chip select rises. Every other frame is dropped.
//
//   Parameters
//     SYNC_STAGES : flops per input synchronizer (>= 2)
//     MAX_ADDR    : highest register address that accepts writes
//
//   Ports
//     clk, rst_n      : system clock, asynchronous active-low reset
//     spi             : SPI pins (slave modport of spi_reg_peripheral_if)
//     en_reg_out_7_0  : register 0x00
//     en_reg_out_15_8 : register 0x01
//     en_reg_pwm_7_0  : register 0x02
//     en_reg_pwm_15_8 : register 0x03
//     pwm_duty_cycle  : register 0x04
//     wr_strobe       : one-cycle pulse in the cycle a register is updated
// -----------------------------------------------------------------------------
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_reg_peripheral_if.slave  spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 wr_strobe
);

  localparam logic [4:0] FRAME_BITS    = 5'd16;
  localparam logic [6:0] MAX_ADDR_FLD  = 7'(MAX_ADDR);

  typedef enum logic [6:0] {
    ADDR_OUT_LO = 7'h00,
    ADDR_OUT_HI = 7'h01,
    ADDR_PWM_LO = 7'h02,
    ADDR_PWM_HI = 7'h03,
    ADDR_DUTY   = 7'h04
  } reg_addr_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers, edge detection and post-reset arming
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;
  logic [SYNC_STAGES:0]   warm;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic armed;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];
  // A chain that is flushing out its reset preset can fake an edge; edges are
  // ignored until every synchronizer stage has seen a real pin value. This is
  // what rejects a frame whose ncs was already low at reset release.
  assign armed  = warm[SYNC_STAGES];

  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchronizers reset to the idle bus (sclk=0, ncs=1) so that
      // leaving reset on a quiet bus never looks like an SPI edge.
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
      warm      <= '0;
      sclk_rise <= 1'b0;
      ncs_fall  <= 1'b0;
      ncs_rise  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // value of its neighbour, which is what makes this a shift chain.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0],  spi.ncs};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      // Edge pulses are registered so downstream logic sees clean flops.
      sclk_rise <= armed &  sclk_s & ~sclk_d;
      ncs_fall  <= armed & ~ncs_s  &  ncs_d;
      ncs_rise  <= armed &  ncs_s  & ~ncs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame capture and register commit
  // ---------------------------------------------------------------------------
  logic [4:0]  bit_cnt;
  logic [15:0] shift_q;
  logic        in_frame;   // set by a seen ncs_fall, cleared by ncs_rise

  logic        frame_ok;
  reg_addr_e   frame_addr;

  assign frame_addr = reg_addr_e'(shift_q[14:8]);
  assign frame_ok   = in_frame && (bit_cnt == FRAME_BITS) && shift_q[15]
                      && (shift_q[14:8] <= MAX_ADDR_FLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt         <= '0;
      shift_q         <= '0;
      in_frame        <= 1'b0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (ncs_fall) begin
        bit_cnt  <= '0;
        shift_q  <= '0;
        in_frame <= 1'b1;
      end else if (ncs_rise) begin
        in_frame <= 1'b0;
        if (frame_ok) begin
          wr_strobe <= 1'b1;
          case (frame_addr)
            ADDR_OUT_LO: en_reg_out_7_0  <= shift_q[7:0];
            ADDR_OUT_HI: en_reg_out_15_8 <= shift_q[7:0];
            ADDR_PWM_LO: en_reg_pwm_7_0  <= shift_q[7:0];
            ADDR_PWM_HI: en_reg_pwm_15_8 <= shift_q[7:0];
            ADDR_DUTY:   pwm_duty_cycle  <= shift_q[7:0];
            default: ;
          endcase
        end
      end else if (sclk_rise && in_frame && (bit_cnt != FRAME_BITS)) begin
        // in_frame already implies ncs is low. Once 16 bits are in, the
        // counter saturates and the shift register holds, so over-length
        // frames keep their first 16 bits.
        shift_q <= {shift_q[14:0], copi_s};
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_peripheral
//   Directed bench for spi_reg_peripheral. SCLK runs at clk/10. Each valid
//   write is pushed to a scoreboard queue when its frame is sent and popped
//   when wr_strobe appears; the register file is also compared against a
//   bench-side model after every frame.
// -----------------------------------------------------------------------------
module tb_spi_reg_peripheral;

  localparam int SYNC     = 2;
  localparam int MAX_ADDR = 4;
  localparam int HALF     = 5;   // clk periods per SCLK phase

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_peripheral_if spi ();

  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  spi_reg_peripheral #(
    .SYNC_STAGES (SYNC),
    .MAX_ADDR    (MAX_ADDR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe)
  );

  logic [7:0] dut_regs [5];
  assign dut_regs[0] = en_reg_out_7_0;
  assign dut_regs[1] = en_reg_out_15_8;
  assign dut_regs[2] = en_reg_pwm_7_0;
  assign dut_regs[3] = en_reg_pwm_15_8;
  assign dut_regs[4] = pwm_duty_cycle;

  logic [7:0] exp_regs [5];
  wr_t        sb_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;
  bit saw_ff      = 1'b0;

  // Passive monitors: total strobes, and any commit of 0xFF to the duty cycle.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      if (pwm_duty_cycle === 8'hFF) saw_ff = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s reg%0d", tag, i), 32'(dut_regs[i]), 32'(exp_regs[i]));
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = bits[i];
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
    end
  endtask

  // Send n bits (MSB first) and close the frame. fresh_fall = 0 means ncs is
  // already low (no falling edge for this frame), so the model rejects it.
  task automatic frame(input logic [31:0] bits, input int n,
                       input bit fresh_fall, input string tag);
    logic [15:0] f;
    bit          valid;
    int          seen;
    int          width;
    wr_t         e;
    f     = '0;
    valid = 1'b0;
    if (n >= 16) begin
      f     = 16'(bits >> (n - 16));
      valid = fresh_fall && f[15] && (f[14:8] <= 7'(MAX_ADDR));
    end
    if (fresh_fall) begin
      spi.ncs = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    shift_bits(bits, n);
    repeat (HALF) @(negedge clk);
    if (valid) sb_q.push_back(wr_t'{addr: f[10:8], data: f[7:0]});
    spi.ncs = 1'b1;
    seen  = 0;
    width = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (wr_strobe === 1'b1) begin
        width++;
        if (seen == 0) seen = i;
      end
    end
    if (valid) begin
      check({tag, " latency"}, 32'(seen), 32'(SYNC + 2));
      check({tag, " strobe width"}, 32'(width), 32'd1);
      e = sb_q.pop_front();
      exp_regs[e.addr] = e.data;
      check({tag, " committed"}, 32'(dut_regs[e.addr]), 32'(e.data));
    end else begin
      check({tag, " no strobe"}, 32'(width), 32'd0);
    end
    check_regs(tag);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;

    // Reset with a noisy bus.
    rst_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      spi.sclk = 1'($urandom);
      spi.copi = 1'($urandom);
      spi.ncs  = 1'($urandom);
    end
    check("reset wr_strobe", 32'(wr_strobe), 32'd0);
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_regs("reset");
    check("reset strobes", 32'(strobe_cnt), 32'd0);

    // One write per address.
    frame(32'h80F0, 16, 1'b1, "wr0");
    frame(32'h81CC, 16, 1'b1, "wr1");
    frame(32'h82AA, 16, 1'b1, "wr2");
    frame(32'h8355, 16, 1'b1, "wr3");
    frame(32'h8480, 16, 1'b1, "wr4");
    check("five strobes", 32'(strobe_cnt), 32'd5);

    // Rejected frames: read, out-of-range address, truncated.
    frame(32'h0412, 16, 1'b1, "read");
    frame(32'h8512, 16, 1'b1, "addr5");
    frame(32'h0848, 12, 1'b1, "short");
    check("reject strobes", 32'(strobe_cnt), 32'd5);

    // Over-length: extra 1-bits after the first 16 are ignored.
    frame(32'h8233F, 20, 1'b1, "long");

    // Reset in the middle of a write of 0xFF to the duty cycle.
    spi.ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(32'h84, 8);
    rst_n    = 1'b0;
    spi.ncs  = 1'b1;
    spi.sclk = 1'b0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_regs("midreset");
    frame(32'h8407, 16, 1'b1, "after reset");
    check("no 0xFF commit", 32'(saw_ff), 32'd0);

    // Frame already in progress (ncs low) when reset releases: rejected.
    rst_n   = 1'b0;
    spi.ncs = 1'b0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame(32'h8099, 16, 1'b0, "low at release");

    // SCLK noise with ncs high must not disturb the next frame.
    for (int i = 0; i < 30; i++) begin
      spi.sclk = ~spi.sclk;
      spi.copi = 1'($urandom);
      repeat (3) @(negedge clk);
    end
    frame(32'h8101, 16, 1'b1, "after noise");
    check("total strobes", 32'(strobe_cnt), 32'd8);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
